miner_work_dispatcher: RTL and testbench

- Parametrised nonce-dispatch and golden-ticket collection unit for a multi-core rolled SHA-256d miner.
- Accepts jobs (midstate + 96-bit header tail + start nonce) over a valid/ready handshake and drives CORES hasher pairs with interleaved nonces plus shared loop control (cnt/feedback).
- Checks each core's final-hash MSW and reports exact, offset-corrected golden nonces through a FIFO, so host software does no nonce correction.

---
 rtl/miner_pkg.sv | 39 +++
 rtl/miner_work_dispatcher_gn_fifo.sv | 59 +++++
 rtl/miner_work_dispatcher.sv | 190 +++++++++++++++++++
 tb/tb_miner_work_dispatcher.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg
// Shared definitions for the rolled SHA-256d miner: the SHA-256 initial hash
// value, the fixed padding words of an 80-byte block header, the dispatcher
// state type, the nonce type and the lowest-set-bit picker that the golden
// nonce collector uses to serialise simultaneous hits.
package miner_pkg;

  typedef logic [31:0] nonce_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } disp_state_t;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Padding word following the nonce and the bit lengths of the two messages
  // (80-byte header, then the 32-byte first digest).
  localparam logic [31:0] PAD_ONE        = 32'h80000000;
  localparam logic [31:0] PAD_LEN_HEADER = 32'h00000280;
  localparam logic [31:0] PAD_LEN_DIGEST = 32'h00000100;

  // Index of the lowest set bit; returns 0 for an empty mask. Sixteen bits
  // cover the largest supported core count.
  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/miner_work_dispatcher_gn_fifo.sv
// gn_fifo
// Small synchronous FIFO built as a shift register so the head entry is always
// a flop. A push into a full FIFO is ignored unless a pop happens in the same
// cycle, in which case both take effect.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   push        write push_data when not full (or when popping)
//   push_data   entry to append
//   pop         remove the head entry when not empty
//   head        current head entry (registered)
//   full/empty  occupancy flags
module gn_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CNT_W-1:0] count;
  logic             pop_ok;
  logic             push_ok;
  logic [IDX_W-1:0] wr_idx;

  // When popping, everything shifts down one slot, so the new entry lands one
  // position lower than the current count.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    head    = mem[0];
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    wr_idx  = pop_ok ? IDX_W'(count - 1'b1) : IDX_W'(count);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
      end
      if (push_ok) mem[wr_idx] <= push_data;
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/miner_work_dispatcher.sv
// miner_work_dispatcher
// Hands jobs to CORES rolled SHA-256d hasher pairs with interleaved nonces,
// sequences the shared round-group counter, checks each core's final hash MSW
// OFFSET check cycles after its nonce was presented and queues the exact
// golden nonces for the host.
// A job scans from the aligned start nonce up to the top of the 32-bit nonce
// space; the last issue group is the one whose successor would wrap to zero.
// Ports:
//   work_*            job handshake (midstate, header tail, start nonce)
//   core_state/tail   registered job data broadcast to all cores
//   core_nonce        nonce of core i at [32i+31:32i]
//   core_cnt          round-group counter, core_feedback high when cnt != 0
//   hit_msw           final hash bits [255:224] of each core
//   gn_valid/ready    golden nonce FIFO head handshake, gn_nonce = value
//   busy/done         job progress, overflow = a golden nonce was lost
module miner_work_dispatcher
  import miner_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int LOOP_LOG2  = 3,
  parameter int CNT_W      = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1,
  parameter int OFFSET     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  work_valid,
  output logic                  work_ready,
  input  logic [255:0]          work_midstate,
  input  logic [95:0]           work_tail,
  input  logic [31:0]           work_nonce_start,
  output logic [255:0]          core_state,
  output logic [95:0]           core_tail,
  output logic [32*CORES-1:0]   core_nonce,
  output logic [CNT_W-1:0]      core_cnt,
  output logic                  core_feedback,
  input  logic [32*CORES-1:0]   hit_msw,
  output logic                  gn_valid,
  input  logic                  gn_ready,
  output logic [31:0]           gn_nonce,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int     LOOP       = 1 << LOOP_LOG2;
  localparam int     FLUSH_W    = $clog2(OFFSET + 1);
  localparam nonce_t CORES_N    = nonce_t'(CORES);
  localparam nonce_t ALIGN_MASK = ~nonce_t'(CORES - 1);

  disp_state_t        state;
  nonce_t             issue_base;
  nonce_t             check_base;
  nonce_t             pend_base;
  logic [FLUSH_W-1:0] flush;
  logic [CORES-1:0]   pend;

  logic               active;
  logic               last_cnt;
  logic               check_cycle;
  logic               accept;
  logic               issue_end;
  logic               check_end;
  logic [CORES-1:0]   hits;
  logic [CORES-1:0]   pend_left;
  logic [15:0]        pend_wide;
  logic [3:0]         pick_idx;
  logic               pend_push;
  nonce_t             push_nonce;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;

  // Job switches only happen at an issue boundary while running, so a core
  // never sees its input change in the middle of a folded transform.
  always_comb begin
    active        = (state == RUN) || (state == DRAIN);
    last_cnt      = (core_cnt == CNT_W'(LOOP - 1));
    check_cycle   = active && (core_cnt == '0);
    work_ready    = (state != RUN) || last_cnt;
    accept        = work_valid && work_ready;
    busy          = active;
    core_feedback = active && (core_cnt != '0);
    issue_end     = ((issue_base + CORES_N) == nonce_t'(0));
    check_end     = ((check_base + CORES_N) == nonce_t'(0));
  end

  always_comb begin
    core_nonce = '0;
    hits       = '0;
    for (int i = 0; i < CORES; i++) begin
      core_nonce[32*i +: 32] = issue_base + nonce_t'(i);
      hits[i]                = (hit_msw[32*i +: 32] == 32'd0);
    end
  end

  // Pending hits leave one per cycle, lowest core first; pend & (pend - 1)
  // is the mask with that lowest bit removed.
  always_comb begin
    pend_wide              = '0;
    pend_wide[CORES-1:0]   = pend;
    pick_idx               = lowest_set(pend_wide);
    pend_push              = (pend != '0);
    push_nonce             = pend_base + nonce_t'(pick_idx);
    pend_left              = pend & (pend - CORES'(1));
    gn_valid               = !fifo_empty;
    fifo_drop              = pend_push && fifo_full && !gn_ready;
  end

  // Main sequencer. The first OFFSET check cycles of a job only count down,
  // because the hashes on hit_msw still belong to the previous job.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      core_state <= '0;
      core_tail  <= '0;
      core_cnt   <= '0;
      issue_base <= '0;
      check_base <= '0;
      pend_base  <= '0;
      pend       <= '0;
      flush      <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pend <= pend_left;
      if (accept) begin
        state      <= RUN;
        core_state <= work_midstate;
        core_tail  <= work_tail;
        core_cnt   <= '0;
        issue_base <= work_nonce_start & ALIGN_MASK;
        check_base <= work_nonce_start & ALIGN_MASK;
        flush      <= FLUSH_W'(OFFSET);
        done       <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (active) begin
          core_cnt <= last_cnt ? '0 : core_cnt + 1'b1;
        end else begin
          core_cnt <= '0;
        end

        if ((state == RUN) && last_cnt) begin
          if (issue_end) begin
            state <= DRAIN;
          end else begin
            issue_base <= issue_base + CORES_N;
          end
        end

        if (check_cycle) begin
          if (flush != '0) begin
            flush <= flush - 1'b1;
          end else begin
            // New hits replace whatever was still pending; losing bits is
            // reported through overflow.
            if (hits != '0) begin
              pend      <= hits;
              pend_base <= check_base;
              if (pend_left != '0) overflow <= 1'b1;
            end
            check_base <= check_base + CORES_N;
            if (check_end) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        if (fifo_drop) overflow <= 1'b1;
      end
    end
  end

  gn_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_gn_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pend_push),
    .push_data (push_nonce),
    .pop       (gn_ready),
    .head      (gn_nonce),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_miner_work_dispatcher.sv
// tb_miner_work_dispatcher
// Drives jobs into miner_work_dispatcher, emulates the hasher pipeline (a hash
// is a hit when its nonce belongs to the job's golden set, OFFSET check cycles
// after the nonce was shown) and scores the golden nonce stream against the
// ascending list of golden nonces inside each job's range.
`timescale 1ns/1ps
module tb_miner_work_dispatcher;

  localparam int CORES      = 4;
  localparam int LOOP_LOG2  = 3;
  localparam int CNT_W      = 3;
  localparam int OFFSET     = 17;
  localparam int FIFO_DEPTH = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 work_valid = 1'b0;
  logic                 work_ready;
  logic [255:0]         work_midstate = '0;
  logic [95:0]          work_tail = '0;
  logic [31:0]          work_nonce_start = '0;
  logic [255:0]         core_state;
  logic [95:0]          core_tail;
  logic [32*CORES-1:0]  core_nonce;
  logic [CNT_W-1:0]     core_cnt;
  logic                 core_feedback;
  logic [32*CORES-1:0]  hit_msw = '1;
  logic                 gn_valid;
  logic                 gn_ready = 1'b1;
  logic [31:0]          gn_nonce;
  logic                 busy;
  logic                 done;
  logic                 overflow;

  always #5 clk = ~clk;

  miner_work_dispatcher #(
    .CORES      (CORES),
    .LOOP_LOG2  (LOOP_LOG2),
    .CNT_W      (CNT_W),
    .OFFSET     (OFFSET),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .work_valid       (work_valid),
    .work_ready       (work_ready),
    .work_midstate    (work_midstate),
    .work_tail        (work_tail),
    .work_nonce_start (work_nonce_start),
    .core_state       (core_state),
    .core_tail        (core_tail),
    .core_nonce       (core_nonce),
    .core_cnt         (core_cnt),
    .core_feedback    (core_feedback),
    .hit_msw          (hit_msw),
    .gn_valid         (gn_valid),
    .gn_ready         (gn_ready),
    .gn_nonce         (gn_nonce),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow)
  );

  int                  n_compared = 0;
  int                  n_mismatched = 0;
  logic [31:0]         exp_q[$];
  logic [32*CORES-1:0] pipe[$];
  logic [32*CORES-1:0] emu_grp;
  bit                  golden_map [logic [31:0]];
  int                  ready_mode = 1;
  longint              cycle = 0;
  longint              acc_cycle = 0;
  longint              pop_times[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Consumer: 0 = stalled, 1 = always ready, 2 = ready about 70% of cycles.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       gn_ready = 1'b0;
      1:       gn_ready = 1'b1;
      default: gn_ready = ($urandom_range(9) < 7);
    endcase
  end

  // Hasher emulation: every check cycle the presented nonce group enters a
  // delay line; once OFFSET groups are ahead of it, the oldest one's hashes
  // are shown. All other cycles carry random values, zero included.
  always @(negedge clk) begin
    if (!reset && busy && core_cnt == '0) begin
      pipe.push_back(core_nonce);
      if (pipe.size() > OFFSET) begin
        emu_grp = pipe.pop_front();
        for (int i = 0; i < CORES; i++)
          hit_msw[32*i +: 32] = golden_map.exists(emu_grp[32*i +: 32]) ? 32'd0 : ($urandom | 32'h1);
      end else begin
        for (int i = 0; i < CORES; i++)
          hit_msw[32*i +: 32] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      end
    end else begin
      for (int i = 0; i < CORES; i++)
        hit_msw[32*i +: 32] = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
    end
  end

  // Scoreboard monitor: every accepted golden nonce must be the next expected.
  always @(negedge clk) begin
    if (!reset && gn_valid && gn_ready) begin
      pop_times.push_back(cycle);
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL gn_unexpected: got %0h, expected no entry", gn_nonce);
      end else begin
        check_output("gn_nonce", gn_nonce, exp_q.pop_front());
      end
    end
  end

  task automatic add_golden(input logic [31:0] n, input bit expect_out);
    golden_map[n] = 1'b1;
    if (expect_out) exp_q.push_back(n);
  endtask

  task automatic apply_stimulus(input logic [31:0] start, input logic [255:0] mid,
                                input logic [95:0] tail);
    int guard;
    @(posedge clk);
    #1;
    work_valid       = 1'b1;
    work_midstate    = mid;
    work_tail        = tail;
    work_nonce_start = start;
    guard = 0;
    @(negedge clk);
    while (!work_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_output("accept_ready", work_ready, 1'b1);
    @(posedge clk);
    #1;
    work_valid = 1'b0;
    pipe.delete();
    acc_cycle = cycle;
  endtask

  // Sample at the negedge after n clock edges following the accept edge.
  task automatic at_edge(input int n);
    @(negedge clk);
    while (int'(cycle - acc_cycle) < n) @(negedge clk);
  endtask

  task automatic wait_done(input int limit);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    check_output("job_done", done, 1'b1);
  endtask

  task automatic wait_empty(input int limit);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < limit) begin
      @(negedge clk);
      guard++;
    end
    check_output("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] start;
    logic [31:0] start_al;
    int          groups;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_work_ready", work_ready, 1'b1);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_gn_valid", gn_valid, 1'b0);
    check_output("rst_cnt", core_cnt, 0);
    reset = 1'b0;

    // Start nonce 0: interleave, loop control, first golden after the flush.
    golden_map.delete();
    add_golden(32'h0000000A, 1'b1);
    apply_stimulus(32'h0, {8{32'h01234567}}, {3{32'h89abcdef}});
    at_edge(0);
    check_output("nonce_group0", core_nonce, {32'd3, 32'd2, 32'd1, 32'd0});
    check_output("core_state_load", core_state, {8{32'h01234567}});
    check_output("fb_cnt0", core_feedback, 1'b0);
    at_edge(3);
    check_output("cnt3", core_cnt, 3);
    check_output("fb_cnt3", core_feedback, 1'b1);
    check_output("ready_mid_group", work_ready, 1'b0);
    at_edge(7);
    check_output("fb_cnt7", core_feedback, 1'b1);
    check_output("ready_group_end", work_ready, 1'b1);
    at_edge(8);
    check_output("base_after_8", core_nonce[31:0], 32'd4);
    check_output("fb_wrap", core_feedback, 1'b0);
    at_edge(153);
    check_output("gn_before_hit", gn_valid, 1'b0);
    at_edge(154);
    check_output("gn_valid_hit", gn_valid, 1'b1);
    check_output("gn_value_hit", gn_nonce, 32'h0000000A);
    at_edge(156);
    check_output("gn_single_entry", gn_valid, 1'b0);
    wait_empty(50);

    // Two hits in one check: lowest core first, consecutive cycles.
    golden_map.delete();
    add_golden(32'h00000100, 1'b1);
    add_golden(32'h00000103, 1'b1);
    pop_times.delete();
    apply_stimulus(32'h00000100, {8{32'h0badf00d}}, {3{32'h5a5a5a5a}});
    wait_empty(400);
    check_output("pop_count", pop_times.size(), 2);
    if (pop_times.size() == 2)
      check_output("pop_spacing", pop_times[1] - pop_times[0], 1);

    // End of nonce space: low start bits ignored, four groups, then DRAIN/DONE.
    golden_map.delete();
    for (int n = 32'hF0; n <= 32'hFF; n++)
      if ($urandom_range(3) == 0) add_golden(32'hFFFFFF00 | 32'(n), 1'b1);
    apply_stimulus(32'hFFFFFFF3, {8{32'h13579bdf}}, {3{32'h2468ace0}});
    at_edge(0);
    check_output("wrap_lane0", core_nonce[31:0], 32'hFFFFFFF0);
    check_output("wrap_lane3", core_nonce[127:96], 32'hFFFFFFF3);
    at_edge(24);
    check_output("wrap_group4", core_nonce[31:0], 32'hFFFFFFFC);
    at_edge(40);
    check_output("drain_hold", core_nonce[31:0], 32'hFFFFFFFC);
    check_output("drain_busy", busy, 1'b1);
    check_output("drain_ready", work_ready, 1'b1);
    at_edge(160);
    check_output("done_early", done, 1'b0);
    at_edge(161);
    check_output("done_set", done, 1'b1);
    check_output("done_busy", busy, 1'b0);
    at_edge(165);
    check_output("done_cnt_frozen", core_cnt, 0);
    check_output("done_fb", core_feedback, 1'b0);
    wait_empty(100);

    // Stalled consumer: ten hits into an eight-entry FIFO.
    ready_mode = 0;
    golden_map.delete();
    for (int k = 0; k < 10; k++) add_golden(32'h00002000 + 32'(k), k < FIFO_DEPTH);
    apply_stimulus(32'h00002000, {8{32'hfeedface}}, {3{32'h0}});
    at_edge(170);
    check_output("ovf_set", overflow, 1'b1);
    check_output("ovf_head", gn_nonce, 32'h00002000);
    golden_map.delete();
    apply_stimulus(32'h00005000, {8{32'h11111111}}, {3{32'h22222222}});
    at_edge(0);
    check_output("ovf_cleared", overflow, 1'b0);
    check_output("fifo_kept", gn_valid, 1'b1);
    ready_mode = 2;
    wait_empty(200);

    // Reset in the middle of a run with a golden nonce waiting.
    ready_mode = 0;
    golden_map.delete();
    add_golden(32'h00000300, 1'b1);
    apply_stimulus(32'h00000300, {8{32'h33333333}}, {3{32'h44444444}});
    at_edge(160);
    check_output("pre_reset_gn", gn_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    pipe.delete();
    check_output("async_gn_valid", gn_valid, 1'b0);
    check_output("async_busy", busy, 1'b0);
    check_output("async_cnt", core_cnt, 0);
    check_output("async_state", core_state, 0);
    check_output("async_nonce", core_nonce, {32'd3, 32'd2, 32'd1, 32'd0});
    check_output("async_gn_nonce", gn_nonce, 0);
    @(negedge clk);
    reset = 1'b0;
    ready_mode = 2;
    @(posedge clk);
    #1;
    check_output("post_reset_ready", work_ready, 1'b1);

    // Random jobs near the top of the nonce space.
    for (int j = 0; j < 3; j++) begin
      start    = 32'hFFFFFE00 | 32'($urandom_range(511));
      start_al = start & ~32'(CORES - 1);
      groups   = int'((33'h100000000 - {1'b0, start_al}) / CORES);
      golden_map.delete();
      for (longint n = longint'(start_al); n <= 64'hFFFFFFFF; n++)
        if ($urandom_range(7) == 0) add_golden(32'(n), 1'b1);
      apply_stimulus(start, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                     {$urandom, $urandom, $urandom});
      wait_done(8 * (groups + OFFSET) + 50);
      wait_empty(200);
      check_output("rand_busy", busy, 1'b0);
      check_output("rand_overflow", overflow, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
